// File: rtl/control_unit_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the fetch/decode datapath.
// Outputs decode only from registered state and the fields latched in DECODE.
module control_unit_fsm #(
  parameter int COUNT_W         = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  output logic               WE_mem,
  output logic               WE_reg,
  output logic [1:0]         OP_MEM_I,
  output logic               ADD_SUB,
  output logic               PC_load,
  output logic [2:0]         select_flags,
  output logic [2:0]         state,
  output logic               halt,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_R       = 3'd1,
    CLS_IALU    = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5
  } cls_e;

  function automatic cls_e classify(input logic [6:0] op);
    case (op)
      7'b0110011: classify = CLS_R;
      7'b0010011: classify = CLS_IALU;
      7'b0000011: classify = CLS_LOAD;
      7'b0100011: classify = CLS_STORE;
      7'b1100011: classify = CLS_BRANCH;
      default:    classify = CLS_ILLEGAL;
    endcase
  endfunction

  // Branch funct3 to flag-select code; the two reserved funct3 values fall through to PC+1.
  function automatic logic [2:0] flag_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  flag_sel = 3'b001;
      3'b001:  flag_sel = 3'b010;
      3'b100:  flag_sel = 3'b011;
      3'b101:  flag_sel = 3'b100;
      3'b110:  flag_sel = 3'b101;
      3'b111:  flag_sel = 3'b110;
      default: flag_sel = 3'b000;
    endcase
  endfunction

  state_e             state_r, state_next_s;
  cls_e               cls_r, cls_s;
  logic [2:0]         funct3_r;
  logic               funct7_5_r;
  logic [COUNT_W-1:0] retired_r;
  logic               sub_op_s;
  logic               we_mem_s, we_reg_s, add_sub_s, pc_load_s, halt_s;
  logic [1:0]         op_mem_i_s;
  logic [2:0]         select_flags_s;

  assign cls_s    = classify(opcode);
  assign sub_op_s = (cls_r == CLS_BRANCH) ||
                    ((cls_r == CLS_R) && (funct3_r == 3'b000) && funct7_5_r);

  // State register, DECODE field latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_FETCH;
      cls_r      <= CLS_ILLEGAL;
      funct3_r   <= 3'b000;
      funct7_5_r <= 1'b0;
      retired_r  <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_DECODE) begin
        cls_r      <= cls_s;
        funct3_r   <= funct3;
        funct7_5_r <= funct7_5;
      end
      if (pc_load_s) begin
        retired_r <= retired_r + COUNT_W'(1);
      end
    end
  end

  // Next-state and control decode from registered state only.
  always_comb begin
    state_next_s   = state_r;
    we_mem_s       = 1'b0;
    we_reg_s       = 1'b0;
    op_mem_i_s     = 2'b00;
    add_sub_s      = 1'b0;
    pc_load_s      = 1'b0;
    select_flags_s = 3'b000;
    halt_s         = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (run) begin
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (cls_s != CLS_ILLEGAL) begin
          state_next_s = ST_EXEC;
        end else if (HALT_ON_ILLEGAL) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_WB;
        end
      end
      ST_EXEC: begin
        add_sub_s = sub_op_s;
        case (cls_r)
          CLS_BRANCH: begin
            pc_load_s      = 1'b1;
            select_flags_s = flag_sel(funct3_r);
            state_next_s   = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_next_s = ST_MEM;
          default:             state_next_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        add_sub_s = sub_op_s;
        if (cls_r == CLS_STORE) begin
          we_mem_s     = 1'b1;
          pc_load_s    = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          op_mem_i_s   = 2'b01;
          state_next_s = ST_WB;
        end
      end
      ST_WB: begin
        add_sub_s    = sub_op_s;
        we_reg_s     = (cls_r != CLS_ILLEGAL);
        pc_load_s    = 1'b1;
        op_mem_i_s   = (cls_r == CLS_LOAD) ? 2'b01 : 2'b00;
        state_next_s = ST_FETCH;
      end
      ST_HALT: begin
        halt_s       = 1'b1;
        state_next_s = ST_HALT;
      end
      default: state_next_s = ST_FETCH;
    endcase
  end

  assign WE_mem       = we_mem_s;
  assign WE_reg       = we_reg_s;
  assign OP_MEM_I     = op_mem_i_s;
  assign ADD_SUB      = add_sub_s;
  assign PC_load      = pc_load_s;
  assign select_flags = select_flags_s;
  assign state        = state_r;
  assign halt         = halt_s;
  assign retired      = retired_r;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: an instruction-level model checks two instances every cycle,
// plus directed literal checks of cycle counts, branch flag mapping, halt and reset behaviour.
module tb_control_unit_fsm;

  logic clk = 1'b0;
  logic reset, run, funct7_5;
  logic [6:0] opcode;
  logic [2:0] funct3;

  logic WE_mem_a, WE_reg_a, ADD_SUB_a, PC_load_a, halt_a;
  logic [1:0] OP_MEM_I_a;
  logic [2:0] select_flags_a, state_a;
  logic [15:0] retired_a;
  logic WE_mem_b, WE_reg_b, ADD_SUB_b, PC_load_b, halt_b;
  logic [1:0] OP_MEM_I_b;
  logic [2:0] select_flags_b, state_b;
  logic [3:0] retired_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  control_unit_fsm #(.COUNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .WE_mem(WE_mem_a), .WE_reg(WE_reg_a), .OP_MEM_I(OP_MEM_I_a), .ADD_SUB(ADD_SUB_a),
    .PC_load(PC_load_a), .select_flags(select_flags_a), .state(state_a), .halt(halt_a),
    .retired(retired_a));

  control_unit_fsm #(.COUNT_W(4), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .WE_mem(WE_mem_b), .WE_reg(WE_reg_b), .OP_MEM_I(OP_MEM_I_b), .ADD_SUB(ADD_SUB_b),
    .PC_load(PC_load_b), .select_flags(select_flags_b), .state(state_b), .halt(halt_b),
    .retired(retired_b));

  // Instruction-level model: phase counts cycles since FETCH; class 0 = illegal/NOP,
  // 1 R, 2 I-ALU, 3 LOAD, 4 STORE, 5 BRANCH.
  typedef struct {
    int          phase;
    int          cls;
    logic [2:0]  f3;
    logic        f7;
    bit          halted;
    int unsigned ret;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 1;
      7'b0010011: return 2;
      7'b0000011: return 3;
      7'b0100011: return 4;
      7'b1100011: return 5;
      default:    return 0;
    endcase
  endfunction

  // Index of the PC_load cycle, from the cycles-per-instruction table.
  function automatic int last_phase(input int c);
    case (c)
      5:       return 2;
      3:       return 4;
      0:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input logic rst, input logic rn,
                                    input logic [6:0] op, input logic [2:0] f3,
                                    input logic f7, input bit hoi);
    mdl_t n = m;
    if (!rst) begin
      n.phase = 0; n.cls = 0; n.f3 = 3'd0; n.f7 = 1'b0; n.halted = 1'b0; n.ret = 0;
    end else if (m.halted) begin
      n.halted = 1'b1;
    end else if (m.phase == 0) begin
      n.phase = rn ? 1 : 0;
    end else if (m.phase == 1) begin
      n.cls = cls_of(op); n.f3 = f3; n.f7 = f7;
      if (n.cls == 0 && hoi) n.halted = 1'b1;
      else n.phase = 2;
    end else if (m.phase == last_phase(m.cls)) begin
      n.phase = 0;
      n.ret   = m.ret + 1;
    end else begin
      n.phase = m.phase + 1;
    end
    return n;
  endfunction

  // Packed {state, halt, WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load, select_flags, retired}.
  function automatic logic [28:0] mdl_out(input mdl_t m, input int unsigned ret_mask);
    logic [2:0] st, sf;
    logic last, sub;
    int p, c;
    p = m.phase; c = m.cls;
    if (m.halted) return {3'd7, 1'b1, 9'd0, 16'(m.ret & ret_mask)};
    last = (p >= 2) && (p == last_phase(c));
    case (p)
      0:       st = 3'd0;
      1:       st = 3'd1;
      2:       st = (c == 0) ? 3'd4 : 3'd2;
      3:       st = (c == 3 || c == 4) ? 3'd3 : 3'd4;
      default: st = 3'd4;
    endcase
    sub = (c == 5) || (c == 1 && m.f3 == 3'd0 && m.f7);
    sf  = 3'd0;
    if (c == 5 && p == 2) begin
      case (m.f3)
        3'd0: sf = 3'd1; 3'd1: sf = 3'd2; 3'd4: sf = 3'd3;
        3'd5: sf = 3'd4; 3'd6: sf = 3'd5; 3'd7: sf = 3'd6;
        default: sf = 3'd0;
      endcase
    end
    return {st, 1'b0, last && (c == 4), last && (c >= 1 && c <= 3),
            (c == 3 && p >= 3) ? 2'b01 : 2'b00, (p >= 2) && sub, last, sf,
            16'(m.ret & ret_mask)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    ma <= mdl_next(ma, reset, run, opcode, funct3, funct7_5, 1'b1);
    mb <= mdl_next(mb, reset, run, opcode, funct3, funct7_5, 1'b0);
  end

  // Per-cycle comparison of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_a", {3'd0, state_a, halt_a, WE_mem_a, WE_reg_a, OP_MEM_I_a, ADD_SUB_a,
                        PC_load_a, select_flags_a, retired_a}, {3'd0, mdl_out(ma, 32'hFFFF)});
      check("cycle_b", {3'd0, state_b, halt_b, WE_mem_b, WE_reg_b, OP_MEM_I_b, ADD_SUB_b,
                        PC_load_b, select_flags_b, 12'd0, retired_b}, {3'd0, mdl_out(mb, 32'hF)});
    end
  end

  task automatic do_reset(input int k);
    reset = 1'b0; run = 1'b0;
    repeat (k) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Runs one instruction from FETCH; checks its cycle count and returns outputs of the PC_load cycle.
  task automatic exec(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int ncyc,
                      output logic [2:0] sf, output logic as, output logic wr, output logic wm,
                      output logic [1:0] om);
    int n = 0;
    opcode = op; funct3 = f3; funct7_5 = f7; run = 1'b1;
    sf = 3'd0; as = 1'b0; wr = 1'b0; wm = 1'b0; om = 2'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n++;
      if (PC_load_a) begin
        sf = select_flags_a; as = ADD_SUB_a; wr = WE_reg_a; wm = WE_mem_a; om = OP_MEM_I_a;
        break;
      end
      @(posedge clk); #2;
    end
    check("cpi", 32'(n), 32'(ncyc));
    @(posedge clk); #2;
  endtask

  initial begin
    logic [2:0] sf, sf_tab [8];
    logic as, wr, wm;
    logic [1:0] om;
    int cnt_a, cnt_b;
    sf_tab = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
    reset = 1'b0; run = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    @(posedge clk); #2 chk_en = 1'b1;
    @(posedge clk); #2 reset = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("idle_state", 32'(state_a), 32'd0);
    check("idle_retired", 32'(retired_a), 32'd0);

    exec(7'b0110011, 3'b000, 1'b1, 4, sf, as, wr, wm, om);
    check("sub_wb", {27'd0, wr, as, om, wm}, {27'd0, 1'b1, 1'b1, 2'b00, 1'b0});
    check("sub_retired", 32'(retired_a), 32'd1);
    exec(7'b0010011, 3'b000, 1'b1, 4, sf, as, wr, wm, om);
    check("ialu_addsub", 32'(as), 32'd0);

    do_reset(1);
    exec(7'b0000011, 3'b010, 1'b0, 5, sf, as, wr, wm, om);
    check("load_wb", {29'd0, om, wr}, {29'd0, 2'b01, 1'b1});
    exec(7'b0100011, 3'b010, 1'b0, 4, sf, as, wr, wm, om);
    check("store_mem", {30'd0, wm, wr}, {30'd0, 1'b1, 1'b0});
    check("ls_retired", 32'(retired_a), 32'd2);

    for (int f = 0; f < 8; f++) begin
      exec(7'b1100011, 3'(f), 1'b0, 3, sf, as, wr, wm, om);
      check("br_flags", 32'(sf), 32'(sf_tab[f]));
      check("br_addsub", 32'(as), 32'd1);
    end

    opcode = 7'b1111111; funct3 = 3'd0; funct7_5 = 1'b0; run = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (PC_load_a) cnt_a++;
      if (PC_load_b) cnt_b++;
      @(posedge clk); #2;
    end
    check("halt_no_pcload", 32'(cnt_a), 32'd0);
    check("nop_pcloads", 32'(cnt_b), 32'd4);
    check("halt_state", {28'd0, state_a, halt_a}, {28'd0, 3'd7, 1'b1});
    do_reset(1);
    check("halt_exit", {28'd0, state_a, halt_a}, 32'd0);

    opcode = 7'b0000011; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (state_a == 3'd3) break;
    end
    check("reached_mem", 32'(state_a), 32'd3);
    #1 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1; run = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (WE_reg_a || state_a != 3'd0) cnt_a++;
    end
    check("reset_mid_load", 32'(cnt_a), 32'd0);

    do_reset(1);
    repeat (17) exec(7'b0110011, 3'b000, 1'b0, 4, sf, as, wr, wm, om);
    check("wrap_retired_b", 32'(retired_b), 32'd1);
    check("retired_a_17", 32'(retired_a), 32'd17);
    run = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
